// File: rtl/exe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : exe_pkg
// Description : Shared EXE-stage definitions. Contains the ALU_ctrl codes,
//               the multiplier operation encoding, the multiply sequencer
//               state type and helpers that decode multiply codes.
// Revision    : 1.0 - initial release
// ============================================================================
package exe_pkg;

    // ALU_ctrl codes
    localparam logic [4:0] c_alu_add    = 5'd0;
    localparam logic [4:0] c_alu_sub    = 5'd1;
    localparam logic [4:0] c_alu_sll    = 5'd2;
    localparam logic [4:0] c_alu_slt    = 5'd3;
    localparam logic [4:0] c_alu_sltu   = 5'd4;
    localparam logic [4:0] c_alu_xor    = 5'd5;
    localparam logic [4:0] c_alu_srl    = 5'd6;
    localparam logic [4:0] c_alu_sra    = 5'd7;
    localparam logic [4:0] c_alu_or     = 5'd8;
    localparam logic [4:0] c_alu_and    = 5'd9;
    localparam logic [4:0] c_alu_mul    = 5'd10;
    localparam logic [4:0] c_alu_mulh   = 5'd11;
    localparam logic [4:0] c_alu_mulhsu = 5'd12;
    localparam logic [4:0] c_alu_mulhu  = 5'd13;
    localparam logic [4:0] c_alu_lui    = 5'd14;
    localparam logic [4:0] c_alu_beq    = 5'd15;
    localparam logic [4:0] c_alu_bne    = 5'd16;
    localparam logic [4:0] c_alu_blt    = 5'd17;
    localparam logic [4:0] c_alu_bge    = 5'd18;
    localparam logic [4:0] c_alu_bltu   = 5'd19;
    localparam logic [4:0] c_alu_bgeu   = 5'd20;
    localparam logic [4:0] c_alu_fadd_s = 5'd21;
    localparam logic [4:0] c_alu_fmul_s = 5'd22;
    localparam logic [4:0] c_alu_fsub_s = 5'd23;

    // Multiplier operand signedness
    localparam logic [1:0] c_mu_op_ss = 2'b00;  // signed x signed
    localparam logic [1:0] c_mu_op_su = 2'b01;  // signed x unsigned
    localparam logic [1:0] c_mu_op_uu = 2'b10;  // unsigned x unsigned

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } seq_state_t;

    function automatic logic is_mul(input logic [4:0] code);
        return (code >= c_alu_mul) && (code <= c_alu_mulhu);
    endfunction

    function automatic logic [1:0] mu_op_of(input logic [4:0] code);
        logic [1:0] op;
        op = c_mu_op_ss;
        if (code == c_alu_mulhsu) op = c_mu_op_su;
        if (code == c_alu_mulhu)  op = c_mu_op_uu;
        return op;
    endfunction

    // Only plain mul returns the low word; every other multiply wants the high word.
    function automatic logic sel_hi_of(input logic [4:0] code);
        return code != c_alu_mul;
    endfunction

endpackage
`default_nettype wire

// File: rtl/exe_mul_result_cache.sv
`default_nettype none
// ============================================================================
// Module      : exe_mul_result_cache
// Description : Single-entry store of the last completed product together
//               with its operands and signedness, so a repeated multiply on
//               the same operands (e.g. mulh followed by mul) can skip the
//               multiplier. Built only when EXE_MUL_REUSE_EN is defined.
// Ports       : clk, rst         - clock, synchronous active-high reset
//               i_clr            - invalidate the entry (pipeline flush)
//               i_wr_en          - record a completed product
//               i_wr_a/b/op      - operands and mu_op of that product
//               i_wr_product     - full 2*XLEN product
//               i_rd_a/b/op      - lookup key of the issuing instruction
//               o_hit            - entry valid and key matches
//               o_product        - stored product
// Revision    : 1.0 - initial release
// ============================================================================
`ifdef EXE_MUL_REUSE_EN
module exe_mul_result_cache #(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clr,
    input  logic              i_wr_en,
    input  logic [XLEN-1:0]   i_wr_a,
    input  logic [XLEN-1:0]   i_wr_b,
    input  logic [1:0]        i_wr_op,
    input  logic [2*XLEN-1:0] i_wr_product,
    input  logic [XLEN-1:0]   i_rd_a,
    input  logic [XLEN-1:0]   i_rd_b,
    input  logic [1:0]        i_rd_op,
    output logic              o_hit,
    output logic [2*XLEN-1:0] o_product
);

    logic              r_valid_q,   w_valid_d;
    logic [XLEN-1:0]   r_a_q,       w_a_d;
    logic [XLEN-1:0]   r_b_q,       w_b_d;
    logic [1:0]        r_op_q,      w_op_d;
    logic [2*XLEN-1:0] r_product_q, w_product_d;

    always_comb begin
        w_valid_d   = r_valid_q;
        w_a_d       = r_a_q;
        w_b_d       = r_b_q;
        w_op_d      = r_op_q;
        w_product_d = r_product_q;
        if (i_clr) begin
            w_valid_d = 1'b0;
        end else if (i_wr_en) begin
            w_valid_d   = 1'b1;
            w_a_d       = i_wr_a;
            w_b_d       = i_wr_b;
            w_op_d      = i_wr_op;
            w_product_d = i_wr_product;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid_q   <= 1'b0;
            r_a_q       <= '0;
            r_b_q       <= '0;
            r_op_q      <= '0;
            r_product_q <= '0;
        end else begin
            r_valid_q   <= w_valid_d;
            r_a_q       <= w_a_d;
            r_b_q       <= w_b_d;
            r_op_q      <= w_op_d;
            r_product_q <= w_product_d;
        end
    end

    assign o_hit     = r_valid_q && (r_a_q == i_rd_a) && (r_b_q == i_rd_b) && (r_op_q == i_rd_op);
    assign o_product = r_product_q;

endmodule
`endif
`default_nettype wire

// File: rtl/exe_mul_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : exe_mul_sequencer
// Description : EXE-stage multiply sequencer. Accepts mul/mulh/mulhsu/mulhu,
//               launches an external iterative multiplier with a start/done
//               handshake, stalls the front of the pipeline while it runs and
//               presents the selected product half for one cycle.
//               Optional macro EXE_MUL_REUSE_EN adds a one-entry product cache
//               that completes repeated multiplies without the multiplier.
// Ports       : clk, rst          - clock, synchronous active-high reset
//               flush             - kill any in-flight multiply
//               issue_valid       - EXE holds a valid instruction
//               alu_ctrl          - ALU_ctrl code
//               op_a, op_b        - source operands
//               stall             - hold IF/ID/EXE (combinational)
//               mu_start, mu_kill - registered pulses to the multiplier
//               mu_op, mu_a, mu_b - latched multiplier request
//               mu_done, mu_result- multiplier completion
//               result_valid      - result valid this cycle
//               result            - selected 32-bit product half
//               stall_cnt         - stalled cycles since reset (wraps)
// Revision    : 1.0 - initial release
// ============================================================================
module exe_mul_sequencer
    import exe_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              issue_valid,
    input  logic [4:0]        alu_ctrl,
    input  logic [XLEN-1:0]   op_a,
    input  logic [XLEN-1:0]   op_b,
    output logic              stall,
    output logic              mu_start,
    output logic [1:0]        mu_op,
    output logic [XLEN-1:0]   mu_a,
    output logic [XLEN-1:0]   mu_b,
    output logic              mu_kill,
    input  logic              mu_done,
    input  logic [2*XLEN-1:0] mu_result,
    output logic              result_valid,
    output logic [XLEN-1:0]   result,
    output logic [CNT_W-1:0]  stall_cnt
);

    seq_state_t        r_state_q,     w_state_d;
    logic              r_mu_start_q,  w_mu_start_d;
    logic              r_mu_kill_q,   w_mu_kill_d;
    logic [1:0]        r_mu_op_q,     w_mu_op_d;
    logic [XLEN-1:0]   r_mu_a_q,      w_mu_a_d;
    logic [XLEN-1:0]   r_mu_b_q,      w_mu_b_d;
    logic              r_sel_hi_q,    w_sel_hi_d;
    logic [XLEN-1:0]   r_result_q,    w_result_d;
    logic [CNT_W-1:0]  r_stall_cnt_q, w_stall_cnt_d;

    logic              w_stall;
    logic              w_result_valid;
    logic              w_accept;
    logic              w_complete;
    logic [1:0]        w_req_op;
    logic              w_req_hi;
    logic              w_hit;
    logic [2*XLEN-1:0] w_hit_product;

    assign w_req_op   = mu_op_of(alu_ctrl);
    assign w_req_hi   = sel_hi_of(alu_ctrl);
    assign w_accept   = (r_state_q == IDLE) && issue_valid && is_mul(alu_ctrl) && !flush;
    // Flush beats a same-cycle mu_done, so a killed op never completes.
    assign w_complete = (r_state_q == WAIT) && mu_done && !flush;

`ifdef EXE_MUL_REUSE_EN
    exe_mul_result_cache #(
        .XLEN (XLEN)
    ) u_cache (
        .clk          (clk),
        .rst          (rst),
        .i_clr        (flush),
        .i_wr_en      (w_complete),
        .i_wr_a       (r_mu_a_q),
        .i_wr_b       (r_mu_b_q),
        .i_wr_op      (r_mu_op_q),
        .i_wr_product (mu_result),
        .i_rd_a       (op_a),
        .i_rd_b       (op_b),
        .i_rd_op      (w_req_op),
        .o_hit        (w_hit),
        .o_product    (w_hit_product)
    );
`else
    assign w_hit         = 1'b0;
    assign w_hit_product = '0;
`endif

    always_comb begin
        w_state_d      = r_state_q;
        w_mu_start_d   = 1'b0;
        w_mu_kill_d    = 1'b0;
        w_mu_op_d      = r_mu_op_q;
        w_mu_a_d       = r_mu_a_q;
        w_mu_b_d       = r_mu_b_q;
        w_sel_hi_d     = r_sel_hi_q;
        w_result_d     = r_result_q;
        w_stall        = 1'b0;
        w_result_valid = 1'b0;

        case (r_state_q)
            IDLE: begin
                w_stall = w_accept;
                if (w_accept) begin
                    w_mu_op_d  = w_req_op;
                    w_mu_a_d   = op_a;
                    w_mu_b_d   = op_b;
                    w_sel_hi_d = w_req_hi;
                    if (w_hit) begin
                        w_state_d  = HOLD;
                        w_result_d = w_req_hi ? w_hit_product[2*XLEN-1:XLEN]
                                              : w_hit_product[XLEN-1:0];
                    end else begin
                        w_state_d    = WAIT;
                        w_mu_start_d = 1'b1;
                    end
                end
            end
            WAIT: begin
                w_stall = 1'b1;
                if (flush) begin
                    w_state_d   = IDLE;
                    w_mu_kill_d = 1'b1;
                end else if (mu_done) begin
                    w_state_d  = HOLD;
                    w_result_d = r_sel_hi_q ? mu_result[2*XLEN-1:XLEN]
                                            : mu_result[XLEN-1:0];
                end
            end
            HOLD: begin
                // Pipeline advances past the multiply this cycle; never re-issue.
                w_result_valid = !flush;
                w_state_d      = IDLE;
            end
            default: begin
                w_state_d = IDLE;
            end
        endcase

        w_stall_cnt_d = r_stall_cnt_q + CNT_W'(w_stall);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q     <= IDLE;
            r_mu_start_q  <= 1'b0;
            r_mu_kill_q   <= 1'b0;
            r_mu_op_q     <= '0;
            r_mu_a_q      <= '0;
            r_mu_b_q      <= '0;
            r_sel_hi_q    <= 1'b0;
            r_result_q    <= '0;
            r_stall_cnt_q <= '0;
        end else begin
            r_state_q     <= w_state_d;
            r_mu_start_q  <= w_mu_start_d;
            r_mu_kill_q   <= w_mu_kill_d;
            r_mu_op_q     <= w_mu_op_d;
            r_mu_a_q      <= w_mu_a_d;
            r_mu_b_q      <= w_mu_b_d;
            r_sel_hi_q    <= w_sel_hi_d;
            r_result_q    <= w_result_d;
            r_stall_cnt_q <= w_stall_cnt_d;
        end
    end

    assign stall        = w_stall;
    assign mu_start     = r_mu_start_q;
    assign mu_kill      = r_mu_kill_q;
    assign mu_op        = r_mu_op_q;
    assign mu_a         = r_mu_a_q;
    assign mu_b         = r_mu_b_q;
    assign result_valid = w_result_valid;
    assign result       = r_result_q;
    assign stall_cnt    = r_stall_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_exe_mul_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_exe_mul_sequencer
// Description : Self-checking bench for exe_mul_sequencer. Directed cases
//               followed by randomized multiplies with random multiplier
//               latency and flushes, checked cycle by cycle against a
//               transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_exe_mul_sequencer;

    localparam int XLEN  = 32;
    localparam int CNT_W = 32;

    logic              clk;
    logic              rst;
    logic              flush;
    logic              issue_valid;
    logic [4:0]        alu_ctrl;
    logic [XLEN-1:0]   op_a;
    logic [XLEN-1:0]   op_b;
    logic              stall;
    logic              mu_start;
    logic [1:0]        mu_op;
    logic [XLEN-1:0]   mu_a;
    logic [XLEN-1:0]   mu_b;
    logic              mu_kill;
    logic              mu_done;
    logic [2*XLEN-1:0] mu_result;
    logic              result_valid;
    logic [XLEN-1:0]   result;
    logic [CNT_W-1:0]  stall_cnt;

    exe_mul_sequencer #(
        .XLEN  (XLEN),
        .CNT_W (CNT_W)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .issue_valid  (issue_valid),
        .alu_ctrl     (alu_ctrl),
        .op_a         (op_a),
        .op_b         (op_b),
        .stall        (stall),
        .mu_start     (mu_start),
        .mu_op        (mu_op),
        .mu_a         (mu_a),
        .mu_b         (mu_b),
        .mu_kill      (mu_kill),
        .mu_done      (mu_done),
        .mu_result    (mu_result),
        .result_valid (result_valid),
        .result       (result),
        .stall_cnt    (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    logic [31:0] exp_cnt;
    bit          c_valid;
    logic [31:0] c_a;
    logic [31:0] c_b;
    logic [1:0]  c_op;

    function automatic logic [63:0] ref_product(input logic [4:0] code, input logic [31:0] a,
                                                input logic [31:0] b);
        logic [63:0] ea;
        logic [63:0] eb;
        ea = (code == 5'd13) ? {32'b0, a} : {{32{a[31]}}, a};
        eb = (code == 5'd12 || code == 5'd13) ? {32'b0, b} : {{32{b[31]}}, b};
        return ea * eb;
    endfunction

    function automatic logic [1:0] ref_op(input logic [4:0] code);
        if (code == 5'd12) return 2'b01;
        if (code == 5'd13) return 2'b10;
        return 2'b00;
    endfunction

    // One instruction presented at cycle 0; lat = multiplier latency after
    // mu_start; f = cycle (relative to issue) carrying flush, -1 for none.
    task automatic run_op(input logic [4:0] code, input logic [31:0] a, input logic [31:0] b,
                          input int lat, input int f, input bit iv);
        bit          mul;
        bit          hit;
        bit          e_stall;
        bit          e_start;
        bit          e_kill;
        bit          e_rv;
        int          hold;
        int          nc;
        logic [63:0] prod;
        logic [31:0] exp_res;

        mul     = iv && (code >= 5'd10) && (code <= 5'd13) && (f != 0);
        prod    = ref_product(code, a, b);
        exp_res = (code == 5'd10) ? prod[31:0] : prod[63:32];
        hit     = 1'b0;
`ifdef EXE_MUL_REUSE_EN
        hit = mul && c_valid && (c_a == a) && (c_b == b) && (c_op == ref_op(code));
`endif
        hold = hit ? 1 : lat + 2;
        nc   = mul ? hold + 2 : 2;
        if (f + 2 > nc) nc = f + 2;

        for (int k = 0; k < nc; k++) begin
            issue_valid = iv && (k == 0);
            alu_ctrl    = (k == 0) ? code : 5'd0;
            op_a        = (k == 0) ? a : $urandom;
            op_b        = (k == 0) ? b : $urandom;
            flush       = (k == f);
            if (mul && !hit) mu_done = (k == lat + 1);
            else             mu_done = (k == 1) && ($urandom_range(0, 1) == 1);
            mu_result   = (mul && !hit && k == lat + 1) ? prod : {$urandom, $urandom};

            @(negedge clk);
            if (k == 0) check_eq("stall_cnt", 64'(stall_cnt), 64'(exp_cnt));
            e_stall = mul && ((k == 0) || (!hit && k >= 1 && k <= lat + 1 && (f < 0 || k <= f)));
            e_start = mul && !hit && (k == 1);
            e_kill  = mul && !hit && (f >= 1) && (f <= lat + 1) && (k == f + 1);
            e_rv    = mul && (k == hold) && !(f >= 1 && f <= hold);
            check_eq("stall", 64'(stall), 64'(e_stall));
            check_eq("mu_start", 64'(mu_start), 64'(e_start));
            check_eq("mu_kill", 64'(mu_kill), 64'(e_kill));
            check_eq("result_valid", 64'(result_valid), 64'(e_rv));
            if (e_start) begin
                check_eq("mu_op", 64'(mu_op), 64'(ref_op(code)));
                check_eq("mu_a", 64'(mu_a), 64'(a));
                check_eq("mu_b", 64'(mu_b), 64'(b));
            end
            if (e_rv) check_eq("result", 64'(result), 64'(exp_res));
            exp_cnt = exp_cnt + 32'(e_stall);
            @(posedge clk);
            #1;
        end

        if (mul && !hit && !(f >= 1 && f <= lat + 1)) begin
            c_valid = 1'b1;
            c_a     = a;
            c_b     = b;
            c_op    = ref_op(code);
        end
        if (f >= 0) c_valid = 1'b0;
    endtask

    task automatic idle_inputs();
        flush       = 1'b0;
        issue_valid = 1'b0;
        alu_ctrl    = 5'd0;
        op_a        = '0;
        op_b        = '0;
        mu_done     = 1'b0;
        mu_result   = '0;
    endtask

    task automatic check_reset_values();
        check_eq("rst_stall", 64'(stall), 64'd0);
        check_eq("rst_mu_start", 64'(mu_start), 64'd0);
        check_eq("rst_mu_kill", 64'(mu_kill), 64'd0);
        check_eq("rst_result_valid", 64'(result_valid), 64'd0);
        check_eq("rst_result", 64'(result), 64'd0);
        check_eq("rst_mu_a", 64'(mu_a), 64'd0);
        check_eq("rst_mu_b", 64'(mu_b), 64'd0);
        check_eq("rst_mu_op", 64'(mu_op), 64'd0);
        check_eq("rst_stall_cnt", 64'(stall_cnt), 64'd0);
    endtask

    initial begin
        logic [4:0]  code;
        logic [31:0] ra;
        logic [31:0] rb;
        int          lat;
        int          f;
        bit          iv;

        idle_inputs();
        rst     = 1'b1;
        exp_cnt = '0;
        c_valid = 1'b0;
        c_a     = '0;
        c_b     = '0;
        c_op    = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_reset_values();
        @(posedge clk);
        #1;

        // Directed cases
        run_op(5'd10, 32'd3, 32'hFFFF_FFFE, 4, -1, 1'b1);
        run_op(5'd13, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, -1, 1'b1);
        run_op(5'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, -1, 1'b1);
        run_op(5'd12, 32'hFFFF_FFFF, 32'd2, 1, -1, 1'b1);
        run_op(5'd10, 32'd5, 32'd6, 4, 3, 1'b1);
        run_op(5'd10, 32'd5, 32'd6, 1, -1, 1'b1);
        run_op(5'd0, 32'd1, 32'd2, 0, -1, 1'b1);
        run_op(5'd15, 32'd1, 32'd2, 0, -1, 1'b1);
        run_op(5'd11, 32'd7, 32'd9, 3, -1, 1'b1);
        run_op(5'd10, 32'd7, 32'd9, 3, -1, 1'b1);
        run_op(5'd5, 32'd0, 32'd0, 0, 0, 1'b1);
        run_op(5'd10, 32'd7, 32'd9, 2, -1, 1'b1);
        run_op(5'd11, 32'd4, 32'd4, 2, 4, 1'b1);

        // Reset during WAIT: no kill, everything back to reset values
        issue_valid = 1'b1;
        alu_ctrl    = 5'd10;
        op_a        = 32'd11;
        op_b        = 32'd13;
        @(posedge clk);
        #1;
        idle_inputs();
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_reset_values();
        exp_cnt = '0;
        c_valid = 1'b0;
        @(posedge clk);
        #1;
        run_op(5'd10, 32'd11, 32'd13, 1, -1, 1'b1);

        // Randomized traffic
        for (int n = 0; n < 300; n++) begin
            code = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 23))
                                               : 5'($urandom_range(10, 13));
            if ($urandom_range(0, 2) != 0) begin
                ra = $urandom;
                rb = $urandom;
            end
            lat = int'($urandom_range(0, 5));
            f   = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, lat + 2)) : -1;
            iv  = ($urandom_range(0, 7) != 0);
            run_op(code, ra, rb, lat, f, iv);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/exe_mul_sequencer.md
Name: exe_mul_sequencer

Overview:
- Multi-cycle sequencer for the EXE-stage multiply path.
- Recognises multiply ALU_ctrl codes: mul=10, mulh=11, mulhsu=12, mulhu=13.
- Launches an external iterative multiplier over a start/done handshake and stalls the pipeline while the multiplier works.
- Returns the selected 32-bit product half to the EXE result mux.
- Non-multiply codes pass through with no stall.

Parameters:
XLEN, 32, operand/result width
CNT_W, 32, width of the stall-cycle performance counter

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
flush  in  1  EXE flush (branch mispredict/trap); kills any in-flight op
issue_valid  in  1  EXE stage holds a valid instruction
alu_ctrl  in  5  ALU_ctrl code of the EXE instruction
op_a  in  XLEN  rs1 operand
op_b  in  XLEN  rs2 operand
stall  out  1  hold IF/ID/EXE; combinational
mu_start  out  1  one-cycle start pulse to multiplier; registered
mu_op  out  2  00 = signed×signed, 01 = signed×unsigned, 10 = unsigned×unsigned
mu_a  out  XLEN  latched operand a
mu_b  out  XLEN  latched operand b
mu_kill  out  1  one-cycle abort pulse to multiplier; registered
mu_done  in  1  product valid, single-cycle pulse
mu_result  in  2*XLEN  full product
result_valid  out  1  mul result valid this cycle
result  out  XLEN  selected product half
stall_cnt  out  CNT_W  cycles with stall=1 since reset; wraps

Behaviour:
- Clock/reset: clock port is clk. rst is synchronous and active-high.
- Reset values: state=IDLE; mu_start=0, mu_kill=0, result_valid=0; result=0, mu_a=0, mu_b=0, mu_op=0; stall_cnt=0.
- is_mul = alu_ctrl in {10..13}.
- Op mapping: mul→00 (low word); mulh→00 (high); mulhsu→01 (high); mulhu→10 (high).
- FSM states: IDLE, WAIT, HOLD.
- IDLE:
  - stall = issue_valid & is_mul & ~flush.
  - On that condition: latch op_a/op_b/mu_op and the hi/lo select; go to WAIT.
  - mu_start=1 in the following cycle only.
- WAIT:
  - stall=1.
  - On mu_done: capture result = select ? mu_result[2*XLEN-1:XLEN] : mu_result[XLEN-1:0]; go to HOLD.
  - mu_done in the same cycle as mu_start is legal and is captured.
- HOLD:
  - stall=0, result_valid=1 for exactly one cycle so the pipeline latches the result and advances.
  - Next state is IDLE unconditionally; the held instruction is never re-issued.
- Latency: with mu_done L≥0 cycles after mu_start, result_valid occurs at acceptance cycle + L + 2.
- Flush:
  - From WAIT or HOLD: next state IDLE, result_valid=0.
  - From WAIT only: mu_kill pulses 1 cycle.
  - Flush has priority over mu_done in the same cycle.
  - Flush in IDLE blocks acceptance.
- Stray mu_done in IDLE is ignored.
- rst mid-operation: same as flush, but no mu_kill pulse (the multiplier is reset too). All registers return to reset values.
- Non-mul alu_ctrl: stall=0, result_valid=0, no mu_start.
- stall_cnt increments each cycle stall=1; it wraps at 2^CNT_W.

Optional Feature:
EXE_MUL_REUSE_EN
- With the macro: keep the last completed 64-bit product, its operands and its mu_op, plus a valid bit. The valid bit is cleared on rst and flush only.
- Hit condition: an IDLE acceptance whose op_a, op_b and mu_op all match and the valid bit is set (e.g. mulh then mul on the same operands).
- On a hit: no mu_start; go directly to HOLD. result_valid appears at acceptance cycle + 1, and stall=1 during the acceptance cycle only.
- Without the macro: no cache; every multiply uses the handshake.

Decomposition:
- Shared package (exe_pkg):
  - ALU_ctrl code localparams: add..fsub_s, 0..23.
  - mu_op encoding constants.
  - seq_state_t enum {IDLE, WAIT, HOLD}.
  - is_mul() function.
- Sub-module exe_mul_result_cache: holds the product, operands, op and valid bit; instantiated only under EXE_MUL_REUSE_EN.

Test Plan:
- Case 1: mul, a=3, b=0xFFFFFFFE, model L=4 → mu_op=00, mu_start 1 cycle after issue; stall high 6 cycles; result=0xFFFFFFFA, result_valid 1 cycle; stall_cnt=6.
- Case 2: mulhu, a=b=0xFFFFFFFF, L=0 → mu_op=10; result=0xFFFFFFFE two cycles after acceptance.
- Case 3: mulh, a=b=0xFFFFFFFF → result=0x00000000. mulhsu, a=0xFFFFFFFF, b=2 → mu_op=01, result=0xFFFFFFFF.
- Case 4: flush 2 cycles into WAIT, then mu_done → mu_kill pulse, IDLE, no result_valid. A following mul issue proceeds normally.
- Case 5: alu_ctrl=0 (add) or 15 (beq) with issue_valid=1 → stall=0, no mu_start, stall_cnt unchanged. rst asserted during WAIT → all outputs at reset values next cycle.
- Case 6 (EXE_MUL_REUSE_EN): mulh 7×9, then mul 7×9 → second op completes in 1 cycle with result=63 and no mu_start. A flush in between forces a full handshake.
